// File: rtl/labarc_swi_pkg.sv
// Shared types and default timing for the switch-word merger.
// Ownership encoding plus the switch width used by the filter and top.
package labarc_swi_pkg;

    typedef enum logic [0:0] {
        OWN_BOARD = 1'b0,
        OWN_JTAG  = 1'b1
    } owner_t;

    localparam int unsigned NSWI                 = 8;
    localparam int unsigned DEF_NSYNC            = 2;
    localparam int unsigned DEF_STABLE_CYCLES    = 4;
    localparam int unsigned DEF_IDLE_TIMEOUT     = 50_000_000;

endpackage

// File: rtl/swi_stable_filter.sv
// Per-source synchronizer and stability filter: a word is accepted only after it has been
// seen unchanged for STABLE_CYCLES consecutive synced samples.
module swi_stable_filter
    import labarc_swi_pkg::*;
#(
    parameter int unsigned NSYNC         = DEF_NSYNC,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned W             = NSWI
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_async,
    output logic [W-1:0] o_accepted,
    output logic         o_changed
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CntMax = CW'(STABLE_CYCLES);

    logic [W-1:0]  r_sync [NSYNC];
    logic [W-1:0]  r_cand;
    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_base;
    logic          r_chg;

    logic [W-1:0]  w_synced;
    logic          w_reload;
    logic [CW-1:0] w_cnt_d;
    logic          w_load;

    always_comb begin
        w_synced = r_sync[NSYNC-1];
        w_reload = (w_synced != r_cand);
        w_cnt_d  = r_cnt;
        if (w_reload) begin
            w_cnt_d = CW'(1);
        end else if (r_cnt != CntMax) begin
            w_cnt_d = r_cnt + CW'(1);
        end
        // Accept only on the cycle the count arrives at the limit, not while it sits there.
        w_load = (w_cnt_d == CntMax) && (w_reload || (r_cnt != CntMax));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NSYNC; i++) begin
                r_sync[i] <= '0;
            end
            r_cand <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_base <= 1'b0;
            r_chg  <= 1'b0;
        end else begin
            r_sync[0] <= i_async;
            for (int i = 1; i < NSYNC; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_cand <= w_synced;
            r_cnt  <= w_cnt_d;
            if (w_load) begin
                r_acc <= w_synced;
            end
            r_base <= r_base | w_load;
            // The first acceptance only establishes the baseline.
            r_chg  <= w_load && r_base && (w_synced != r_acc);
        end
    end

    assign o_accepted = r_acc;
    assign o_changed  = r_chg;

endmodule

// File: rtl/swi_jtag_sync.sv
// Merges the virtual-JTAG and physical-board switch words into one registered word,
// handing ownership to whichever source changed last, with an idle timeout back to board.
module swi_jtag_sync
    import labarc_swi_pkg::*;
#(
    parameter int unsigned NSYNC         = DEF_NSYNC,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned IDLE_TIMEOUT  = DEF_IDLE_TIMEOUT
) (
    input  logic            clk_2,
    input  logic            reset,
    input  logic [NSWI-1:0] SWI_JTAG,
    input  logic [NSWI-1:0] SWI_BOARD,
    output logic [NSWI-1:0] SWI,
    output logic            jtag_owner,
    output logic            swi_changed,
    output logic [NSWI-1:0] swi_change_mask
);

    localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IdleMax = IW'(IDLE_TIMEOUT);

    owner_t          r_state;
    owner_t          w_state_d;
    logic [IW-1:0]   r_idle;
    logic [IW-1:0]   w_idle_d;
    logic [NSWI-1:0] r_swi;
    logic [NSWI-1:0] w_swi_d;
    logic [NSWI-1:0] r_mask;
    logic            r_chg;

    logic [NSWI-1:0] w_jacc;
    logic [NSWI-1:0] w_bacc;
    logic            w_jchg;
    logic            w_bchg;

    swi_stable_filter #(
        .NSYNC         (NSYNC),
        .STABLE_CYCLES (STABLE_CYCLES),
        .W             (NSWI)
    ) u_filt_jtag (
        .i_clk      (clk_2),
        .i_rst      (reset),
        .i_async    (SWI_JTAG),
        .o_accepted (w_jacc),
        .o_changed  (w_jchg)
    );

    swi_stable_filter #(
        .NSYNC         (NSYNC),
        .STABLE_CYCLES (STABLE_CYCLES),
        .W             (NSWI)
    ) u_filt_board (
        .i_clk      (clk_2),
        .i_rst      (reset),
        .i_async    (SWI_BOARD),
        .o_accepted (w_bacc),
        .o_changed  (w_bchg)
    );

    always_comb begin
        w_state_d = r_state;
        w_idle_d  = '0;
        unique case (r_state)
            OWN_BOARD: begin
                // Board wins a simultaneous change, so JTAG only takes over alone.
                if (w_jchg && !w_bchg) begin
                    w_state_d = OWN_JTAG;
                end
            end
            OWN_JTAG: begin
                if (!w_jchg) begin
                    w_idle_d = (r_idle != IdleMax) ? r_idle + IW'(1) : r_idle;
                end
                if (w_bchg || (w_idle_d == IdleMax)) begin
                    w_state_d = OWN_BOARD;
                end
            end
        endcase
        w_swi_d = (w_state_d == OWN_JTAG) ? w_jacc : w_bacc;
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_state <= OWN_BOARD;
            r_idle  <= '0;
            r_swi   <= '0;
            r_mask  <= '0;
            r_chg   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_idle  <= (w_state_d == OWN_JTAG) ? w_idle_d : '0;
            r_swi   <= w_swi_d;
            r_mask  <= w_swi_d ^ r_swi;
            r_chg   <= (w_swi_d != r_swi);
        end
    end

    assign SWI             = r_swi;
    assign jtag_owner      = (r_state == OWN_JTAG);
    assign swi_changed     = r_chg;
    assign swi_change_mask = r_mask;

endmodule

// File: tb/tb_swi_jtag_sync.sv
// Bench for swi_jtag_sync: directed switch sequences, expected change pulses queued
// by the stimulus and matched by an independent monitor.
module tb_swi_jtag_sync;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [7:0] SWI_JTAG;
    logic [7:0] SWI_BOARD;
    logic [7:0] SWI;
    logic       jtag_owner;
    logic       swi_changed;
    logic [7:0] swi_change_mask;

    typedef struct packed {
        logic [7:0] swi;
        logic [7:0] mask;
        logic       owner;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   t0     = 0;

    swi_jtag_sync #(
        .NSYNC         (2),
        .STABLE_CYCLES (4),
        .IDLE_TIMEOUT  (20)
    ) dut (
        .clk_2           (clk_2),
        .reset           (reset),
        .SWI_JTAG        (SWI_JTAG),
        .SWI_BOARD       (SWI_BOARD),
        .SWI             (SWI),
        .jtag_owner      (jtag_owner),
        .swi_changed     (swi_changed),
        .swi_change_mask (swi_change_mask)
    );

    always #5 clk_2 = ~clk_2;

    always @(posedge clk_2) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic wait_swi(input logic [7:0] v, input string name);
        int n = 0;
        while (SWI !== v && n < 30) begin
            @(posedge clk_2);
            #1;
            n++;
        end
        check(name, 32'(SWI), 32'(v));
    endtask

    // Monitor: every change pulse must match the oldest queued expectation.
    always @(posedge clk_2) begin
        #1;
        if (swi_changed === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got swi=%0h mask=%0h owner=%0b expected none",
                         SWI, swi_change_mask, jtag_owner);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pulse", 32'({SWI, swi_change_mask, jtag_owner}), 32'(e));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        SWI_JTAG  = 8'h00;
        SWI_BOARD = 8'h00;
        cycles(3);
        check("rst_swi", 32'(SWI), 32'h0);
        check("rst_owner", 32'(jtag_owner), 32'h0);
        check("rst_changed", 32'(swi_changed), 32'h0);
        check("rst_mask", 32'(swi_change_mask), 32'h0);

        // Board word from reset; JTAG baselines at 0 meanwhile.
        @(negedge clk_2);
        reset     = 1'b0;
        SWI_BOARD = 8'h05;
        q.push_back('{swi: 8'h05, mask: 8'h05, owner: 1'b0});
        cycles(8);
        check("board_swi", 32'(SWI), 32'h05);
        check("board_owner", 32'(jtag_owner), 32'h0);
        cycles(2);

        // JTAG takes ownership.
        @(negedge clk_2);
        SWI_JTAG = 8'h81;
        q.push_back('{swi: 8'h81, mask: 8'h84, owner: 1'b1});
        wait_swi(8'h81, "jtag_swi");
        t0 = cyc;
        check("jtag_owner", 32'(jtag_owner), 32'h1);

        // Short board glitch is ignored.
        @(negedge clk_2);
        SWI_BOARD = 8'h04;
        cycles(3);
        @(negedge clk_2);
        SWI_BOARD = 8'h05;
        cycles(10);
        check("glitch_owner", 32'(jtag_owner), 32'h1);
        check("glitch_swi", 32'(SWI), 32'h81);

        // Idle timeout hands back to the board.
        q.push_back('{swi: 8'h05, mask: 8'h84, owner: 1'b0});
        begin
            int n = 0;
            while (jtag_owner !== 1'b0 && n < 40) begin
                @(posedge clk_2);
                #1;
                n++;
            end
        end
        check("timeout_owner", 32'(jtag_owner), 32'h0);
        check("timeout_cycles", 32'(cyc - t0), 32'd20);
        check("timeout_swi", 32'(SWI), 32'h05);

        // Simultaneous change: board wins.
        @(negedge clk_2);
        SWI_JTAG = 8'h11;
        q.push_back('{swi: 8'h11, mask: 8'h14, owner: 1'b1});
        wait_swi(8'h11, "jtag2_swi");
        @(negedge clk_2);
        SWI_BOARD = 8'hA0;
        SWI_JTAG  = 8'h22;
        q.push_back('{swi: 8'hA0, mask: 8'hB1, owner: 1'b0});
        wait_swi(8'hA0, "both_swi");
        cycles(2);
        check("both_owner", 32'(jtag_owner), 32'h0);
        check("both_swi_hold", 32'(SWI), 32'hA0);

        // Reset in the middle of a JTAG filter run.
        @(negedge clk_2);
        SWI_JTAG = 8'h5A;
        cycles(2);
        @(negedge clk_2);
        reset = 1'b1;
        @(posedge clk_2);
        #1;
        check("mid_rst_swi", 32'(SWI), 32'h0);
        check("mid_rst_owner", 32'(jtag_owner), 32'h0);
        check("mid_rst_changed", 32'(swi_changed), 32'h0);
        check("mid_rst_mask", 32'(swi_change_mask), 32'h0);
        @(negedge clk_2);
        reset = 1'b0;
        q.push_back('{swi: 8'hA0, mask: 8'hA0, owner: 1'b0});
        wait_swi(8'hA0, "post_rst_swi");
        cycles(10);
        check("post_rst_owner", 32'(jtag_owner), 32'h0);
        check("post_rst_swi_hold", 32'(SWI), 32'hA0);

        cycles(2);
        check("queue_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1);
    end

endmodule

// File: doc/swi_jtag_sync.md
SWI_JTAG_SYNC -- requirements
Module: swi_jtag_sync

Interface
REQ-001 SHALL have parameter NSYNC, default 2, meaning synchronizer flop depth per input bit.
REQ-002 SHALL have parameter STABLE_CYCLES, default 4, meaning consecutive equal samples needed to accept a value.
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 50_000_000, meaning clk_2 cycles without JTAG activity before ownership returns to board.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port: clk_2  input  1  system clock; all logic on its rising edge.
REQ-006 Port: reset  input  1  synchronous, active-high reset.
REQ-007 Port: SWI_JTAG  input  8  switch word from the virtual-JTAG update-DR domain; asynchronous to clk_2.
REQ-008 Port: SWI_BOARD  input  8  physical board switches; asynchronous, may bounce.
REQ-009 Port: SWI  output  8  merged, registered switch word for the design under test.
REQ-010 Port: jtag_owner  output  1  1 = SWI driven from the JTAG source, 0 = from the board.
REQ-011 Port: swi_changed  output  1  single-cycle pulse when SWI changes value.
REQ-012 Port: swi_change_mask  output  8  SWI_old XOR SWI_new; valid only while swi_changed = 1, else 0.

Function
REQ-013 Each source SHALL pass through an NSYNC-deep flop chain per bit before any other use.
REQ-014 Each source SHALL have a filter: candidate register plus counter; counter resets to 1 when the synced word differs from candidate (candidate loads the new word), else increments, saturating at STABLE_CYCLES.
REQ-015 A filter SHALL load its accepted register with candidate on the cycle the counter reaches STABLE_CYCLES; accepted changes only then.
REQ-016 Each filter SHALL hold a baseline flag, cleared by reset, set by the first acceptance; the first acceptance after reset SHALL NOT count as a change.
REQ-017 Ownership FSM states: BOARD (reset state), JTAG.
REQ-018 BOARD -> JTAG SHALL occur when the JTAG accepted word changes with its baseline set.
REQ-019 JTAG -> BOARD SHALL occur when the board accepted word changes with its baseline set, or the idle counter reaches IDLE_TIMEOUT.
REQ-020 If both sources report a change in the same cycle, board SHALL win: next state BOARD.
REQ-021 Idle counter SHALL clear on every JTAG accepted change and on entry to JTAG, increment in JTAG, saturate at IDLE_TIMEOUT, and hold 0 in BOARD; width SHALL be clog2(IDLE_TIMEOUT+1).
REQ-022 SWI SHALL register, one cycle after the FSM update, the accepted word of the source selected by the next-state owner; jtag_owner SHALL equal the registered state.
REQ-023 Latency from a stable input change to SWI SHALL be NSYNC+STABLE_CYCLES+1 cycles, +1 for asynchronous sampling (7..8 at defaults).
REQ-024 swi_changed and swi_change_mask SHALL be registered in the same cycle SWI takes its new value; an ownership switch to an identical word SHALL NOT pulse.
REQ-025 A glitch shorter than STABLE_CYCLES consecutive synced samples SHALL NOT alter accepted, SWI or ownership.

Reset
REQ-026 On reset: sync chains, candidates, accepted, counters, baselines, idle counter, SWI, swi_change_mask = 0; swi_changed = 0; state = BOARD; jtag_owner = 0.
REQ-027 Reset asserted mid-filter or mid-timeout SHALL discard all progress; outputs SHALL take reset values on the next edge.

Structure
REQ-028 Package labarc_swi_pkg SHALL hold owner_t enum {OWN_BOARD, OWN_JTAG}, NSWI = 8, and default timing constants.
REQ-029 Filter SHALL be one sub-module swi_stable_filter (sync chain, candidate, counter, accepted, baseline), instantiated twice.

Verification
REQ-030 Reset, then SWI_BOARD = 8'h05 held 10 cycles -> SWI = 8'h05 by cycle 8, jtag_owner = 0, swi_changed pulses once with mask 8'h05.
REQ-031 SWI_JTAG 8'h00 baselined, then 8'h81 held -> jtag_owner = 1, SWI = 8'h81 within 8 cycles, one pulse, mask = SWI_prev ^ 8'h81.
REQ-032 In JTAG, SWI_BOARD toggles bit 0 for 3 cycles then returns -> no state change, SWI unchanged, no pulse.
REQ-033 IDLE_TIMEOUT = 20, in JTAG with no activity -> jtag_owner = 0 exactly 20 cycles after last JTAG change, SWI = board word.
REQ-034 Board and JTAG accepted words change in the same cycle -> jtag_owner = 0, SWI = new board word.
REQ-035 Reset asserted 2 cycles into a JTAG filter run -> all outputs 0 next cycle; prior JTAG word treated as baseline, no ownership change.
